// File: rtl/bundle_pkg.sv
// Shared types and sizing for the 128-bit fetch bundle serializer.
package bundle_pkg;

  localparam int LANE_W   = 32;
  localparam int LANES    = 4;
  localparam int BUNDLE_W = LANE_W * LANES;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/lane_pick4.sv
// Combinational lane finder: lowest set mask bit at or above a start index,
// plus whether any set bit lies strictly above the start index.
module lane_pick4
  import bundle_pkg::*;
(
  input  logic [LANES-1:0] mask,
  input  lane_idx_t        start,
  output lane_idx_t        first,
  output logic             found,
  output logic             none_above
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    first      = '0;
    found      = 1'b0;
    none_above = 1'b1;
    // Descending scan: the last hit written is the lowest qualifying lane.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && (lane_idx_t'(i) >= start)) begin
        first = lane_idx_t'(i);
        found = 1'b1;
      end
      if (mask[i] && (lane_idx_t'(i) > start)) begin
        none_above = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bundle_serializer_128.sv
// Drains a 128-bit fetch bundle into 32-bit words, one set lane per beat.
// Optional zero-bubble chaining of bundles: define BUNDLE_SER_BACK_TO_BACK_EN.
module bundle_serializer_128
  import bundle_pkg::state_t;
  import bundle_pkg::lane_idx_t;
  import bundle_pkg::IDLE;
  import bundle_pkg::DRAIN;
#(
  parameter int LANE_W = 32,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANE_W*LANES-1:0] in_data,
  input  logic [LANES-1:0]        in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W-1:0]       out_data,
  output logic [1:0]              out_lane,
  output logic                    out_last
);

  state_t                        state;
  logic [LANES-1:0][LANE_W-1:0]  bundle_q;
  logic [LANES-1:0]              rem_mask;
  lane_idx_t                     cur;

  lane_idx_t                     next_lane;
  logic                          next_unused_found;
  logic                          no_higher;
  lane_idx_t                     init_lane;
  logic                          init_found;
  logic                          init_unused_none_above;

  // Clearing the presented lane leaves exactly the lanes still to follow it.
  lane_pick4 u_pick_next (
    .mask       (rem_mask & ~(LANES'(1) << cur)),
    .start      (cur),
    .first      (next_lane),
    .found      (next_unused_found),
    .none_above (no_higher)
  );

  lane_pick4 u_pick_init (
    .mask       (in_mask),
    .start      (2'd0),
    .first      (init_lane),
    .found      (init_found),
    .none_above (init_unused_none_above)
  );

  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? bundle_q[cur] : '0;
  assign out_lane  = out_valid ? cur : 2'd0;
  assign out_last  = out_valid && no_higher;

`ifdef BUNDLE_SER_BACK_TO_BACK_EN
  assign in_ready = !areset && !flush &&
                    ((state == IDLE) || (out_last && out_ready));
`else
  assign in_ready = !areset && !flush && (state == IDLE);
`endif

  wire accept = in_valid && in_ready;

  // NOTE: all state updates use non-blocking assignments; a later assignment
  // in the same edge (a new bundle load) overrides an earlier one.
  always_ff @(posedge clk) begin
    if (areset) begin
      state    <= IDLE;
      bundle_q <= '0;
      rem_mask <= '0;
      cur      <= '0;
    end else if (flush) begin
      state    <= IDLE;
      rem_mask <= '0;
    end else begin
      if (state == DRAIN && out_ready) begin
        rem_mask[cur] <= 1'b0;
        if (no_higher) begin
          state <= IDLE;
        end else begin
          cur <= next_lane;
        end
      end
      if (accept && init_found) begin
        bundle_q <= in_data;
        rem_mask <= in_mask;
        cur      <= init_lane;
        state    <= DRAIN;
      end
    end
  end

endmodule

// File: tb/tb_bundle_serializer_128.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-of-beats reference model.
module tb_bundle_serializer_128;

  logic         clk = 1'b0;
  logic         areset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_mask;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_lane;
  logic         out_last;

  always #5 clk = ~clk;

  bundle_serializer_128 dut (
    .clk       (clk),
    .areset    (areset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  lane;
    logic        last;
  } beat_t;

  beat_t q[$];
  bit    just_reset;
  int    n_checks = 0;
  int    n_bad    = 0;

`ifdef BUNDLE_SER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                      input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  // One cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [127:0] d, input logic [3:0] m, input logic ordy);
    logic exp_ready;
    areset = r; flush = f; in_valid = iv; in_data = d; in_mask = m; out_ready = ordy;
    #1;
    exp_ready = !r && !f && ((q.size() == 0) || (B2B && q.size() == 1 && ordy));
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_lane", 32'(out_lane), 32'(q[0].lane));
      check("out_last", 32'(out_last), 32'(q[0].last));
    end else if (just_reset) begin
      check("rst_data", out_data, 32'd0);
      check("rst_lane", 32'(out_lane), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (f) begin
        q.delete();
      end else begin
        if (ordy && q.size() != 0) void'(q.pop_front());
        if (iv && exp_ready) begin
          for (int i = 0; i < 4; i++) begin
            if (m[i]) q.push_back('{d[32*i +: 32], 2'(i), (m >> (i + 1)) == 4'd0});
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 4'h0, ordy);
  endtask

  logic [127:0] full_b;

  initial begin
    full_b = mk(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    areset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = full_b;
    in_mask = 4'hF; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    just_reset = 1'b1;

    // Reset held with a bundle offered: nothing captured.
    step(1'b1, 1'b0, 1'b1, full_b, 4'hF, 1'b1);
    step(1'b1, 1'b0, 1'b1, full_b, 4'hF, 1'b1);
    idle(1, 1'b1);

    // Full bundle, then drain with an idle cycle after.
    step(1'b0, 1'b0, 1'b1, full_b, 4'hF, 1'b1);
    idle(5, 1'b1);

    // Sparse and empty masks.
    step(1'b0, 1'b0, 1'b1, mk(32'hA0, 32'hA1, 32'hA2, 32'hA3), 4'b1010, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 1'b0, 1'b1, full_b, 4'b0000, 1'b1);
    idle(2, 1'b1);

    // Backpressure on lane 1.
    step(1'b0, 1'b0, 1'b1, full_b, 4'hF, 1'b1);
    idle(1, 1'b1);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // Flush while lane 2 is presented, with a competing bundle offered.
    step(1'b0, 1'b0, 1'b1, full_b, 4'hF, 1'b1);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, mk(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003), 4'hF, 1'b1);
    step(1'b0, 1'b0, 1'b1, mk(32'hBEEF0000, 32'hBEEF0001, 32'hBEEF0002, 32'hBEEF0003), 4'b0110, 1'b1);
    idle(4, 1'b1);

    // Back-to-back full bundles offered continuously.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, mk(32'(i), 32'(i + 100), 32'(i + 200), 32'(i + 300)), 4'hF, 1'b1);
    end
    idle(6, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) != 0,
           {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom),
           $urandom_range(0, 3) != 0);
    end
    idle(6, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
